// File: rtl/bip_pkg.sv
// Shared encodings and default widths for the BIP execution datapath.
package bip_pkg;

    localparam int unsigned LEN_DATA  = 16;
    localparam int unsigned LEN_ADDR  = 11;
    localparam int unsigned LEN_MUX_A = 2;
    localparam int unsigned LEN_CNT   = 32;

    typedef enum logic [1:0] {
        SEL_A_RAM  = 2'd0,
        SEL_A_IMM  = 2'd1,
        SEL_A_ALU  = 2'd2,
        SEL_A_HOLD = 2'd3
    } sel_a_e;

    localparam logic SEL_B_RAM = 1'b0;
    localparam logic SEL_B_IMM = 1'b1;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic {
        DBG_IDLE = 1'b0,
        DBG_ACK  = 1'b1
    } dbg_state_e;

endpackage

// File: rtl/bip_alu.sv
// Combinational add/sub with signed overflow detection.
module bip_alu
    import bip_pkg::*;
#(
    parameter int unsigned len_data = LEN_DATA
) (
    input  logic [len_data-1:0] a,
    input  logic [len_data-1:0] b,
    input  logic                op,
    output logic [len_data-1:0] result,
    output logic                ovf
);

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        if (op == ALU_SUB) begin
            result = a - b;
            ovf    = (a[len_data-1] != b[len_data-1]) && (result[len_data-1] != a[len_data-1]);
        end else begin
            result = a + b;
            ovf    = (a[len_data-1] == b[len_data-1]) && (result[len_data-1] != a[len_data-1]);
        end
    end

endmodule

// File: rtl/bip_datapath.sv
// BIP execution datapath: accumulator, operand muxes, flags, cycle counter
// and a four-phase debug snapshot port.
module bip_datapath
    import bip_pkg::*;
#(
    parameter int unsigned len_data  = LEN_DATA,
    parameter int unsigned len_addr  = LEN_ADDR,
    parameter int unsigned len_mux_a = LEN_MUX_A,
    parameter int unsigned len_cnt   = LEN_CNT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [len_mux_a-1:0] SelA,
    input  logic                 SelB,
    input  logic                 WrAcc,
    input  logic                 Op,
    input  logic                 RdRam,
    input  logic [len_addr-1:0]  Operand,
    input  logic                 Halt,
    input  logic [len_data-1:0]  RamRdData,
    output logic [len_addr-1:0]  RamAddr,
    output logic [len_data-1:0]  RamWrData,
    output logic [len_data-1:0]  Acc,
    output logic                 Zero,
    output logic                 Neg,
    output logic                 Ovf,
    input  logic                 DbgReq,
    output logic                 DbgAck,
    output logic [len_data-1:0]  DbgAcc,
    output logic [2:0]           DbgFlags,
    output logic [len_cnt-1:0]   DbgCycles
);

    logic [len_data-1:0] ext_operand;
    logic [len_data-1:0] ram_operand;
    logic [len_data-1:0] mux_b;
    logic [len_data-1:0] mux_a;
    logic [len_data-1:0] alu_result;
    logic                alu_ovf;
    logic                acc_wr;
    logic [len_cnt-1:0]  cycle_cnt;
    dbg_state_e          state_q, state_d;
    logic                capture;

    assign ext_operand = {{(len_data-len_addr){Operand[len_addr-1]}}, Operand};
    assign ram_operand = RdRam ? RamRdData : '0;
    assign mux_b       = (SelB == SEL_B_IMM) ? ext_operand : ram_operand;

    bip_alu #(.len_data(len_data)) u_alu (
        .a      (Acc),
        .b      (mux_b),
        .op     (Op),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    always_comb begin
        mux_a = Acc;
        case (SelA)
            SEL_A_RAM: mux_a = ram_operand;
            SEL_A_IMM: mux_a = ext_operand;
            SEL_A_ALU: mux_a = alu_result;
            default:   mux_a = Acc;
        endcase
    end

    assign acc_wr    = WrAcc && (SelA != SEL_A_HOLD);
    assign RamAddr   = Operand;
    assign RamWrData = Acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            Acc  <= '0;
            Zero <= 1'b0;
            Neg  <= 1'b0;
            Ovf  <= 1'b0;
        end else if (acc_wr) begin
            Acc  <= mux_a;
            Zero <= (mux_a == '0);
            Neg  <= mux_a[len_data-1];
            Ovf  <= (SelA == SEL_A_ALU) ? alu_ovf : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if (!Halt && (cycle_cnt != '1)) begin
            cycle_cnt <= cycle_cnt + len_cnt'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DBG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            DBG_IDLE: if (DbgReq) begin
                state_d = DBG_ACK;
                capture = 1'b1;
            end
            DBG_ACK: if (!DbgReq) state_d = DBG_IDLE;
            default: state_d = DBG_IDLE;
        endcase
    end

    assign DbgAck = (state_q == DBG_ACK);

    // Capture reads the pre-edge register values, so a simultaneous Acc write is not seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            DbgAcc    <= '0;
            DbgFlags  <= '0;
            DbgCycles <= '0;
        end else if (capture) begin
            DbgAcc    <= Acc;
            DbgFlags  <= {Ovf, Neg, Zero};
            DbgCycles <= cycle_cnt;
        end
    end

endmodule

// File: tb/tb_bip_datapath.sv
// Directed self-checking bench for bip_datapath, with a narrow-counter
// second instance to exercise counter saturation.
module tb_bip_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  SelA;
    logic        SelB;
    logic        WrAcc;
    logic        Op;
    logic        RdRam;
    logic [10:0] Operand;
    logic        Halt;
    logic [15:0] RamRdData;
    logic        DbgReq;

    logic [10:0] RamAddr;
    logic [15:0] RamWrData;
    logic [15:0] Acc;
    logic        Zero, Neg, Ovf;
    logic        DbgAck;
    logic [15:0] DbgAcc;
    logic [2:0]  DbgFlags;
    logic [31:0] DbgCycles;

    logic [10:0] s_RamAddr;
    logic [15:0] s_RamWrData;
    logic [15:0] s_Acc;
    logic        s_Zero, s_Neg, s_Ovf;
    logic        s_DbgAck;
    logic [15:0] s_DbgAcc;
    logic [2:0]  s_DbgFlags;
    logic [3:0]  s_DbgCycles;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bip_datapath dut (
        .clk(clk), .reset(reset), .SelA(SelA), .SelB(SelB), .WrAcc(WrAcc),
        .Op(Op), .RdRam(RdRam), .Operand(Operand), .Halt(Halt),
        .RamRdData(RamRdData), .RamAddr(RamAddr), .RamWrData(RamWrData),
        .Acc(Acc), .Zero(Zero), .Neg(Neg), .Ovf(Ovf), .DbgReq(DbgReq),
        .DbgAck(DbgAck), .DbgAcc(DbgAcc), .DbgFlags(DbgFlags), .DbgCycles(DbgCycles)
    );

    bip_datapath #(.len_cnt(4)) dut_sat (
        .clk(clk), .reset(reset), .SelA(SelA), .SelB(SelB), .WrAcc(WrAcc),
        .Op(Op), .RdRam(RdRam), .Operand(Operand), .Halt(Halt),
        .RamRdData(RamRdData), .RamAddr(s_RamAddr), .RamWrData(s_RamWrData),
        .Acc(s_Acc), .Zero(s_Zero), .Neg(s_Neg), .Ovf(s_Ovf), .DbgReq(DbgReq),
        .DbgAck(s_DbgAck), .DbgAcc(s_DbgAcc), .DbgFlags(s_DbgFlags), .DbgCycles(s_DbgCycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; SelA = 2'd1; SelB = 1'b0; WrAcc = 1'b1; Op = 1'b0;
        RdRam = 1'b0; Operand = 11'd5; Halt = 1'b1; RamRdData = '0; DbgReq = 1'b0;

        // Reset with a pending write must leave everything cleared
        step(2);
        check("rst_acc", Acc, 0);
        check("rst_flags", {Ovf, Neg, Zero}, 0);
        check("rst_ack", DbgAck, 0);
        check("rst_dbgacc", DbgAcc, 0);
        check("rst_dbgflags", DbgFlags, 0);
        check("rst_dbgcyc", DbgCycles, 0);

        reset = 1'b0;
        Operand = 11'h7FF;
        step(1);
        check("imm_ffff_acc", Acc, 16'hFFFF);
        check("imm_ffff_flags", {Ovf, Neg, Zero}, 3'b010);
        Operand = 11'h000;
        step(1);
        check("imm_zero_acc", Acc, 0);
        check("imm_zero_flags", {Ovf, Neg, Zero}, 3'b001);

        // ALU overflow cases from 0x7FFF
        SelA = 2'd0; RdRam = 1'b1; RamRdData = 16'h7FFF;
        step(1);
        check("ram_7fff", Acc, 16'h7FFF);
        SelA = 2'd2; SelB = 1'b1; Op = 1'b0; Operand = 11'd1; RdRam = 1'b0;
        step(1);
        check("add_ovf_acc", Acc, 16'h8000);
        check("add_ovf_flags", {Ovf, Neg, Zero}, 3'b110);
        Op = 1'b1;
        step(1);
        check("sub_ovf_acc", Acc, 16'h7FFF);
        check("sub_ovf_flags", {Ovf, Neg, Zero}, 3'b100);
        SelA = 2'd1; Op = 1'b0; Operand = 11'd3;
        step(1);
        check("load_clr_ovf_acc", Acc, 16'h0003);
        check("load_clr_ovf_flags", {Ovf, Neg, Zero}, 3'b000);

        // Hold paths
        WrAcc = 1'b0; Operand = 11'd9;
        step(1);
        check("hold_wracc0", Acc, 16'h0003);
        WrAcc = 1'b1; SelA = 2'd3;
        step(1);
        check("hold_sela3", Acc, 16'h0003);

        // ALU with RAM B operand; also a negative immediate subtract
        SelA = 2'd2; SelB = 1'b0; RdRam = 1'b1; RamRdData = 16'h0010; Op = 1'b0;
        step(1);
        check("add_ram", Acc, 16'h0013);
        SelB = 1'b1; Op = 1'b1; Operand = 11'h7FE;
        step(1);
        check("sub_negimm", Acc, 16'h0015);
        check("sub_negimm_flags", {Ovf, Neg, Zero}, 3'b000);

        // RAM path and combinational outputs
        SelA = 2'd0; RdRam = 1'b1; RamRdData = 16'h1234; Operand = 11'h2A5;
        #1;
        check("ramaddr", RamAddr, 11'h2A5);
        check("ramwrdata_pre", RamWrData, 16'h0015);
        step(1);
        check("ram_rd", Acc, 16'h1234);
        check("ramwrdata", RamWrData, 16'h1234);
        RdRam = 1'b0; Operand = 11'h013;
        #1;
        check("ramaddr2", RamAddr, 11'h013);
        step(1);
        check("ram_rd_gated", Acc, 0);
        check("ram_rd_gated_zero", Zero, 1);

        // Debug snapshot sees the old Acc at a simultaneous write
        SelA = 2'd1; Operand = 11'h0AA;
        step(1);
        check("load_aa", Acc, 16'h00AA);
        Operand = 11'h0BB; DbgReq = 1'b1;
        #1;
        check("ack_not_early", DbgAck, 0);
        step(1);
        check("dbg_ack_rise", DbgAck, 1);
        check("dbg_acc_old", DbgAcc, 16'h00AA);
        check("dbg_flags", DbgFlags, 3'b000);
        check("dbg_cyc_halted", DbgCycles, 0);
        check("acc_new", Acc, 16'h00BB);
        Operand = 11'h7FF;
        step(1);
        check("dbg_ack_held", DbgAck, 1);
        check("dbg_acc_frozen", DbgAcc, 16'h00AA);
        check("acc_ffff", Acc, 16'hFFFF);
        DbgReq = 1'b0;
        step(1);
        check("dbg_ack_fall", DbgAck, 0);

        // Cycle counter: run, halt, saturate (second instance has 4-bit counter)
        WrAcc = 1'b0; Halt = 1'b0;
        step(10);
        Halt = 1'b1; DbgReq = 1'b1;
        step(1);
        check("cnt_10", DbgCycles, 10);
        check("sat_cnt_10", s_DbgCycles, 10);
        check("dbg_flags_neg", DbgFlags, 3'b010);
        DbgReq = 1'b0;
        step(6);
        DbgReq = 1'b1;
        step(1);
        check("cnt_halt_10", DbgCycles, 10);
        DbgReq = 1'b0;
        step(1);
        Halt = 1'b0;
        step(20);
        Halt = 1'b1; DbgReq = 1'b1;
        step(1);
        check("cnt_30", DbgCycles, 30);
        check("sat_cnt_15", s_DbgCycles, 4'hF);
        check("sat_ack", s_DbgAck, 1);

        // Reset during ACK aborts the handshake
        reset = 1'b1;
        step(1);
        check("rst_ack_abort", DbgAck, 0);
        check("rst_dbgacc_clr", DbgAcc, 0);
        check("rst_dbgcyc_clr", DbgCycles, 0);
        check("rst_dbgflags_clr", DbgFlags, 0);
        check("rst_acc_clr", Acc, 0);
        reset = 1'b0; DbgReq = 1'b0;
        step(1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bip_datapath.md
Name: bip_datapath

Overview:
Execution datapath of the BIP processor, directly downstream of the control unit. It consumes SelA, SelB, WrAcc, Op, RdRam and Operand, and holds the accumulator. It performs sign extension, operand muxing and add/sub, drives the data-RAM address and write data, and maintains status flags and a cycle counter. A four-phase debug snapshot port lets the UART/debug interface read a consistent copy of the architectural state.

Parameters:
len_data, 16, accumulator/ALU/RAM data width
len_addr, 11, operand and data-RAM address width
len_mux_a, 2, width of SelA
len_cnt, 32, cycle counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
SelA  in  len_mux_a  accumulator source: 0=RAM, 1=ext operand, 2=ALU, 3=hold
SelB  in  1  ALU B operand: 0=RAM, 1=ext operand
WrAcc  in  1  accumulator write enable
Op  in  1  ALU op: 0=add, 1=sub
RdRam  in  1  RAM read qualifier
Operand  in  len_addr  instruction operand field
Halt  in  1  processor halted; freezes cycle counter
RamRdData  in  len_data  data RAM read data (asynchronous read, same cycle)
RamAddr  out  len_addr  data RAM address, equals Operand (combinational)
RamWrData  out  len_data  data RAM write data, equals Acc
Acc  out  len_data  accumulator register
Zero  out  1  last written accumulator value == 0
Neg  out  1  last written accumulator value MSB
Ovf  out  1  signed overflow of last ALU write
DbgReq  in  1  debug snapshot request (level, four-phase)
DbgAck  out  1  snapshot valid / acknowledge
DbgAcc  out  len_data  snapshot of Acc
DbgFlags  out  3  snapshot {Ovf, Neg, Zero}
DbgCycles  out  len_cnt  snapshot of cycle counter

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the rising edge.
- Reset values: Acc=0, Zero=0, Neg=0, Ovf=0, cycle counter=0, DbgAck=0, DbgAcc=0, DbgFlags=0, DbgCycles=0, FSM=IDLE. Reset asserted mid-handshake aborts the handshake to these values.
- Ext operand: Operand sign-extended to len_data bits by replicating Operand[len_addr-1].
- RAM operand: RamRdData when RdRam=1, else forced to 0.
- MuxB: per SelB. ALU: A=Acc, B=MuxB. Result = A+B (Op=0) or A-B (Op=1), modulo 2^len_data, no carry out.
- Signed overflow:
  - add: A and B have the same sign and the result sign differs.
  - sub: A and B have different signs and the result sign differs from A.
- Accumulator update at the edge when WrAcc=1 and SelA!=3:
  - Acc <= MuxA.
  - Zero <= (MuxA==0); Neg <= MuxA[MSB].
  - Ovf <= ALU overflow if SelA=2, else 0.
- WrAcc=0 or SelA=3: Acc and flags hold.
- Single-cycle execution: zero latency from inputs to the next-edge accumulator value.
- RamAddr and RamWrData are combinational. A RAM write in a given cycle stores the pre-edge Acc.
- Cycle counter: increments by 1 each edge when Halt=0. Holds when Halt=1. Saturates at 2^len_cnt-1 with no wrap.
- Debug FSM:
  - IDLE (DbgAck=0): on an edge with DbgReq=1, capture DbgAcc<=Acc, DbgFlags<={Ovf,Neg,Zero}, DbgCycles<=counter, and move to ACK.
  - ACK (DbgAck=1): snapshot frozen. On an edge with DbgReq=0, go to IDLE with DbgAck=0.
  - A new capture needs DbgReq low for at least one edge first.
- Capture samples register contents before any simultaneous update at the same edge, so the snapshot holds the old Acc.
- DbgAck rises one cycle after DbgReq is first sampled high.

Decomposition:
- Shared package bip_pkg: SelA encodings (SEL_A_RAM=0, SEL_A_IMM=1, SEL_A_ALU=2, SEL_A_HOLD=3), SelB encodings, ALU_ADD/ALU_SUB, debug FSM state enum, default widths.
- One sub-module bip_alu: combinational add/sub with overflow output.
- Sign extension, muxes and the FSM stay in bip_datapath.

Test Plan:
- Reset: hold reset 2 cycles with WrAcc=1, SelA=1, Operand=5 -> Acc=0, all flags 0, DbgAck=0, counter 0.
- Load imm: SelA=1, WrAcc=1, Operand=11'h7FF -> Acc=16'hFFFF, Neg=1, Zero=0. Then Operand=0 -> Acc=0, Zero=1.
- ALU: Acc=16'h7FFF, SelB=1, Op=0, SelA=2, Operand=1 -> Acc=16'h8000, Ovf=1. Then Op=1, Operand=1 -> Acc=16'h7FFF, Ovf=1. Then SelA=1 load -> Ovf=0.
- RAM path: RamRdData=16'h1234 with RdRam=1, SelA=0 -> Acc=16'h1234. Same with RdRam=0 -> Acc=0. RamAddr tracks Operand; RamWrData equals Acc.
- Counter: 10 cycles with Halt=0 -> 10. Halt=1 for 5 cycles -> stays 10. Preload near max -> saturates at 32'hFFFFFFFF.
- Debug: Acc=16'h00AA with WrAcc writing 16'h00BB at the same edge DbgReq rises -> DbgAcc=16'h00AA, DbgAck=1 next cycle and held while DbgReq=1. DbgReq drop -> DbgAck=0 after one edge. Reset during ACK -> DbgAck=0 and snapshot cleared.
